// File: rtl/simd_alu_pipe.sv
// simd_alu_pipe: LANES x 32-bit SIMD ALU behind a two-stage valid/ready pipeline (S1 operands, S2 result).
// Define SIMD_ALU_GF_EN to build the GF(2^8) byte opcodes 101 and 110; otherwise those opcodes flag out_err.
module simd_alu_pipe #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*32-1:0]   a,
    input  logic [LANES*32-1:0]   b,
    input  logic [2:0]            select,
    input  logic [LANES-1:0]      lane_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*32-1:0]   result_alu,
    output logic                  out_err,
    output logic [CNT_W-1:0]      op_count
);

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_MUL   = 3'b010,
        OP_XOR   = 3'b011,
        OP_AND   = 3'b100,
        OP_GFMUL = 3'b101,
        OP_XTIME = 3'b110,
        OP_PASS  = 3'b111
    } op_e;

    // S1: captured operands
    logic                 s1_valid_reg;
    logic [LANES*32-1:0]  s1_a_reg;
    logic [LANES*32-1:0]  s1_b_reg;
    op_e                  s1_sel_reg;
    logic [LANES-1:0]     s1_en_reg;

    // S2: registered result
    logic                 s2_valid_reg;
    logic [LANES*32-1:0]  s2_result_reg;
    logic                 s2_err_reg;
    logic [CNT_W-1:0]     op_count_reg;

    logic                 s2_advance;
    logic                 s1_advance;
    logic                 out_fire;
    logic [LANES*32-1:0]  alu_next;
    logic                 err_next;

`ifdef SIMD_ALU_GF_EN
    function automatic logic [7:0] xtime8(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply, reducing by the AES polynomial 0x11B at each doubling.
    function automatic logic [7:0] gf_mul8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = x;
        for (int k = 0; k < 8; k++) begin
            if (y[k]) acc = acc ^ p;
            p = xtime8(p);
        end
        return acc;
    endfunction

    assign err_next = 1'b0;
`else
    assign err_next = (s1_sel_reg == OP_GFMUL) || (s1_sel_reg == OP_XTIME);
`endif

    assign s2_advance = !s2_valid_reg || out_ready;
    assign s1_advance = s1_valid_reg && s2_advance;
    assign in_ready   = !s1_valid_reg || s1_advance;
    assign out_fire   = s2_valid_reg && out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [31:0] la;
            logic [31:0] lb;
            logic [31:0] lr;
            logic [31:0] gf_mul_res;
            logic [31:0] gf_xt_res;

            assign la = s1_a_reg[32*gi +: 32];
            assign lb = s1_b_reg[32*gi +: 32];

`ifdef SIMD_ALU_GF_EN
            always_comb begin
                gf_mul_res = '0;
                gf_xt_res  = '0;
                for (int k = 0; k < 4; k++) begin
                    gf_mul_res[8*k +: 8] = gf_mul8(la[8*k +: 8], lb[8*k +: 8]);
                    gf_xt_res[8*k +: 8]  = xtime8(la[8*k +: 8]);
                end
            end
`else
            assign gf_mul_res = '0;
            assign gf_xt_res  = '0;
`endif

            always_comb begin
                lr = '0;
                if (s1_en_reg[gi]) begin
                    case (s1_sel_reg)
                        OP_ADD:   lr = la + lb;
                        OP_SUB:   lr = la - lb;
                        OP_MUL:   lr = la * lb;
                        OP_XOR:   lr = la ^ lb;
                        OP_AND:   lr = la & lb;
                        OP_GFMUL: lr = gf_mul_res;
                        OP_XTIME: lr = gf_xt_res;
                        OP_PASS:  lr = la;
                        default:  lr = '0;
                    endcase
                end
            end

            assign alu_next[32*gi +: 32] = lr;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_sel_reg   <= OP_ADD;
            s1_en_reg    <= '0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_a_reg   <= a;
                s1_b_reg   <= b;
                s1_sel_reg <= op_e'(select);
                s1_en_reg  <= lane_en;
            end
        end
    end

    // S2 only reloads when it can hand its current beat on, so a stalled result never changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg  <= 1'b0;
            s2_result_reg <= '0;
            s2_err_reg    <= 1'b0;
        end else if (s2_advance) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_result_reg <= alu_next;
                s2_err_reg    <= err_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_reg <= '0;
        end else if (out_fire && (op_count_reg != {CNT_W{1'b1}})) begin
            op_count_reg <= op_count_reg + CNT_W'(1);
        end
    end

    assign out_valid  = s2_valid_reg;
    assign result_alu = s2_result_reg;
    assign out_err    = s2_err_reg;
    assign op_count   = op_count_reg;

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Directed testbench for simd_alu_pipe (LANES=4); a second CNT_W=2 instance shares the inputs for counter saturation.
`timescale 1ns/1ps
module tb_simd_alu_pipe;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] a;
    logic [127:0] b;
    logic [2:0]   select;
    logic [3:0]   lane_en;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] result_alu;
    logic         out_err;
    logic [15:0]  op_count;

    logic         in_ready_s;
    logic         out_valid_s;
    logic [127:0] result_s;
    logic         out_err_s;
    logic [1:0]   op_count_s;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    simd_alu_pipe #(.LANES(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .select(select), .lane_en(lane_en),
        .out_valid(out_valid), .out_ready(out_ready), .result_alu(result_alu),
        .out_err(out_err), .op_count(op_count)
    );

    simd_alu_pipe #(.LANES(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .select(select), .lane_en(lane_en),
        .out_valid(out_valid_s), .out_ready(out_ready), .result_alu(result_s),
        .out_err(out_err_s), .op_count(op_count_s)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [127:0] bp_a(input int k);
        logic [127:0] v;
        for (int i = 0; i < 4; i++) v[32*i +: 32] = 32'(k) * 32'h01000000 + 32'(i) * 32'h10 + 32'h5;
        return v;
    endfunction

    function automatic logic [127:0] bp_exp(input int k);
        logic [127:0] v;
        for (int i = 0; i < 4; i++) v[32*i +: 32] = 32'(k) * 32'h01000000 + 32'(i) * 32'h10 + 32'h1005;
        return v;
    endfunction

    // Tasks start just after a rising edge and return just after a rising edge.
    task automatic apply_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; select = 3'b000; lane_en = 4'hF;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_beat(input logic [127:0] av, input logic [127:0] bv, input logic [2:0] sel,
                            input logic [3:0] en, output logic [127:0] res, output logic err,
                            output int lat, output bit ok);
        int n;
        in_valid = 1'b1; a = av; b = bv; select = sel; lane_en = en; out_ready = 1'b1;
        res = '0; err = 1'b0; lat = 0; ok = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (out_valid) begin
                res = result_alu; err = out_err; lat = n; ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        apply_reset();
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
        total_cnt++; if (result_alu !== 128'h0) $display("FAIL reset_result: got %h expected 0", result_alu); else pass_cnt++;
        total_cnt++; if (out_err !== 1'b0) $display("FAIL reset_out_err: got %b expected 0", out_err); else pass_cnt++;
        total_cnt++; if (op_count !== 16'h0) $display("FAIL reset_op_count: got %0d expected 0", op_count); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        $display("reset: out_valid=%b in_ready=%b op_count=%0d", out_valid, in_ready, op_count);
        @(posedge clk); #1;
    endtask

    task automatic test_latency;
        logic [127:0] res; logic err; int lat; bit ok;
        run_beat({32'h00000010, 32'h7FFFFFFF, 32'h12345678, 32'hFFFFFFFF},
                 {32'h00000020, 32'h00000001, 32'h11111111, 32'h00000001}, 3'b000, 4'hF, res, err, lat, ok);
        total_cnt++; if (!ok) $display("FAIL add_timeout: got no out_valid expected a result"); else pass_cnt++;
        total_cnt++; if (lat !== 2) $display("FAIL add_latency: got %0d expected 2", lat); else pass_cnt++;
        total_cnt++;
        if (res !== {32'h00000030, 32'h80000000, 32'h23456789, 32'h00000000})
            $display("FAIL add_result: got %h expected %h", res, {32'h00000030, 32'h80000000, 32'h23456789, 32'h00000000});
        else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL add_err: got %b expected 0", err); else pass_cnt++;
        $display("add: result=%h lat=%0d err=%b", res, lat, err);
    endtask

    task automatic test_arith;
        logic [127:0] res; logic err; int lat; bit ok;
        run_beat({32'h80000000, 32'h00000000, 32'h00000010, 32'h00000005},
                 {32'h00000001, 32'h00000001, 32'h00000010, 32'h00000007}, 3'b001, 4'hF, res, err, lat, ok);
        total_cnt++;
        if (!ok || res !== {32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFE})
            $display("FAIL sub_result: got %h expected %h", res, {32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFE});
        else pass_cnt++;
        $display("sub: result=%h", res);
        run_beat({32'h00010000, 32'hFFFFFFFF, 32'h00000003, 32'h12345678},
                 {32'h00010000, 32'hFFFFFFFF, 32'h00000007, 32'h00000002}, 3'b010, 4'hF, res, err, lat, ok);
        total_cnt++;
        if (!ok || res !== {32'h00000000, 32'h00000001, 32'h00000015, 32'h2468ACF0})
            $display("FAIL mul_result: got %h expected %h", res, {32'h00000000, 32'h00000001, 32'h00000015, 32'h2468ACF0});
        else pass_cnt++;
        $display("mul: result=%h", res);
    endtask

    task automatic test_logic;
        logic [127:0] res; logic err; int lat; bit ok;
        run_beat({4{32'hF0F0F0F0}}, {32'h0F0F0F0F, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h00000000},
                 3'b011, 4'hF, res, err, lat, ok);
        total_cnt++;
        if (!ok || res !== {32'hFFFFFFFF, 32'h00000000, 32'h0F0F0F0F, 32'hF0F0F0F0})
            $display("FAIL xor_result: got %h expected %h", res, {32'hFFFFFFFF, 32'h00000000, 32'h0F0F0F0F, 32'hF0F0F0F0});
        else pass_cnt++;
        $display("xor: result=%h", res);
        run_beat({4{32'hF0F0F0F0}}, {32'h0F0F0F0F, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h00000000},
                 3'b100, 4'hF, res, err, lat, ok);
        total_cnt++;
        if (!ok || res !== {32'h00000000, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h00000000})
            $display("FAIL and_result: got %h expected %h", res, {32'h00000000, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h00000000});
        else pass_cnt++;
        $display("and: result=%h", res);
        run_beat({4{32'hDEADBEEF}}, {4{32'h11111111}}, 3'b111, 4'b0101, res, err, lat, ok);
        total_cnt++;
        if (!ok || res !== {32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF})
            $display("FAIL pass_lane_en: got %h expected %h", res, {32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF});
        else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL pass_err: got %b expected 0", err); else pass_cnt++;
        $display("pass lane_en=0101: result=%h", res);
    endtask

    task automatic test_gf;
        logic [127:0] res; logic err; int lat; bit ok;
        logic [127:0] exp_mul; logic [127:0] exp_xt; logic exp_err;
`ifdef SIMD_ALU_GF_EN
        exp_mul = {32'h0000001B, 32'h06060606, 32'h000000C1, 32'h632FAFA2};
        exp_xt  = {32'h80808080, 32'h00000000, 32'hE5000000, 32'h1B020406};
        exp_err = 1'b0;
`else
        exp_mul = '0;
        exp_xt  = '0;
        exp_err = 1'b1;
`endif
        run_beat({32'h00000080, 32'h02020202, 32'h00000057, 32'h632FAFA2},
                 {32'h00000002, 32'h03030303, 32'h00000083, 32'h01010101}, 3'b101, 4'hF, res, err, lat, ok);
        total_cnt++; if (!ok || res !== exp_mul) $display("FAIL gfmul_result: got %h expected %h", res, exp_mul); else pass_cnt++;
        total_cnt++; if (err !== exp_err) $display("FAIL gfmul_err: got %b expected %b", err, exp_err); else pass_cnt++;
        $display("gfmul: result=%h err=%b", res, err);
        run_beat({32'h40404040, 32'h00000000, 32'hFF000000, 32'h80010203},
                 {4{32'h12345678}}, 3'b110, 4'hF, res, err, lat, ok);
        total_cnt++; if (!ok || res !== exp_xt) $display("FAIL xtime_result: got %h expected %h", res, exp_xt); else pass_cnt++;
        total_cnt++; if (err !== exp_err) $display("FAIL xtime_err: got %b expected %b", err, exp_err); else pass_cnt++;
        $display("xtime: result=%h err=%b", res, err);
    endtask

    task automatic test_back_to_back;
        logic [127:0] exp;
        out_ready = 1'b1; select = 3'b011; lane_en = 4'hF; b = {4{32'hA5A5A5A5}};
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 6);
            a = bp_a(c);
            @(negedge clk);
            if (c < 6) begin
                total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready c%0d: got %b expected 1", c, in_ready); else pass_cnt++;
            end
            if (c >= 2) begin
                exp = bp_a(c - 2) ^ {4{32'hA5A5A5A5}};
                total_cnt++;
                if (out_valid !== 1'b1 || result_alu !== exp)
                    $display("FAIL b2b_out c%0d: got v=%b %h expected v=1 %h", c, out_valid, result_alu, exp);
                else pass_cnt++;
            end else begin
                total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_fill c%0d: got v=%b expected 0", c, out_valid); else pass_cnt++;
            end
            $display("b2b cycle %0d: in_ready=%b out_valid=%b result=%h", c, in_ready, out_valid, result_alu);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        int sent; int recv; bit stall_prev; bit saw_full; bit extra;
        logic [127:0] held_res;
        apply_reset();
        sent = 0; recv = 0; stall_prev = 0; saw_full = 0; held_res = '0;
        select = 3'b000; lane_en = 4'hF; b = {4{32'h00001000}};
        for (int c = 0; c < 40 && recv < 8; c++) begin
            in_valid = (sent < 8);
            a = bp_a(sent);
            out_ready = !(c >= 3 && c <= 6);
            @(negedge clk);
            if (stall_prev) begin
                total_cnt++;
                if (out_valid !== 1'b1 || result_alu !== held_res)
                    $display("FAIL bp_stable c%0d: got v=%b %h expected v=1 %h", c, out_valid, result_alu, held_res);
                else pass_cnt++;
            end
            stall_prev = out_valid && !out_ready;
            held_res = result_alu;
            if (in_valid && !in_ready) begin
                saw_full = 1'b1;
                total_cnt++; if (sent - recv !== 2) $display("FAIL bp_held c%0d: got %0d expected 2", c, sent - recv); else pass_cnt++;
            end
            if (out_valid && out_ready) begin
                total_cnt++;
                if (result_alu !== bp_exp(recv)) $display("FAIL bp_order beat%0d: got %h expected %h", recv, result_alu, bp_exp(recv));
                else pass_cnt++;
                $display("bp delivered beat %0d: result=%h", recv, result_alu);
                recv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        extra = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) extra = 1'b1;
            @(posedge clk); #1;
        end
        total_cnt++; if (saw_full !== 1'b1) $display("FAIL bp_in_ready_low: got %b expected 1", saw_full); else pass_cnt++;
        total_cnt++; if (recv !== 8) $display("FAIL bp_count: got %0d expected 8", recv); else pass_cnt++;
        total_cnt++; if (extra !== 1'b0) $display("FAIL bp_duplicate: got %b expected 0", extra); else pass_cnt++;
        total_cnt++; if (op_count !== 16'd8) $display("FAIL bp_op_count: got %0d expected 8", op_count); else pass_cnt++;
        total_cnt++; if (op_count_s !== 2'd3) $display("FAIL op_count_saturate: got %0d expected 3", op_count_s); else pass_cnt++;
        $display("bp: delivered=%0d op_count=%0d op_count_sat=%0d", recv, op_count, op_count_s);
    endtask

    task automatic test_reset_midflight;
        bit stale;
        in_valid = 1'b1; out_ready = 1'b0; select = 3'b111; lane_en = 4'hF; a = {4{32'hCAFEF00D}};
        repeat (2) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b expected 1", out_valid); else pass_cnt++;
        total_cnt++; if (op_count !== 16'd8) $display("FAIL mid_pre_count: got %0d expected 8", op_count); else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b expected 0", out_valid); else pass_cnt++;
        total_cnt++; if (op_count !== 16'd0) $display("FAIL mid_op_count: got %0d expected 0", op_count); else pass_cnt++;
        total_cnt++; if (result_alu !== 128'h0) $display("FAIL mid_result: got %h expected 0", result_alu); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                total_cnt++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b expected 1", in_ready); else pass_cnt++;
            end
            if (out_valid) stale = 1'b1;
            @(posedge clk); #1;
        end
        total_cnt++; if (stale !== 1'b0) $display("FAIL mid_stale_beat: got %b expected 0", stale); else pass_cnt++;
        $display("reset mid-flight: stale=%b op_count=%0d", stale, op_count);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; select = 3'b000; lane_en = 4'hF;
        test_reset();
        test_latency();
        test_arith();
        test_logic();
        test_gf();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
